// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares the single UART TX FIFO push port between two ASCII
// byte producers (req0 = SR04 formatter, req1 = DHT11 formatter). Each stream
// is buffered locally and the push port is granted one whole message at a time,
// so messages never interleave and simultaneous byte strobes are never lost.
//
// Optional feature macro: UART_ARB_TAG_EN
//   defined   : a TAG0/TAG1 byte is pushed ahead of every granted message.
//   undefined : raw message bytes only.

// Per-requester byte buffer with an end-of-message counter and a sticky drop flag.
module UartArbFifo #(
  parameter int         DEPTH = 16,
  parameter logic [7:0] EOM   = 8'h0A
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] i_wrData,
  input  logic       i_wrValid,
  input  logic       i_pop,
  output logic [7:0] o_headData,
  output logic       o_empty,
  output logic       o_full,
  output logic       o_hasMsg,
  output logic       o_drainsOnPop,
  output logic       o_overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);
  localparam logic [AW:0] ONE_COUNT  = (AW + 1)'(1);

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wrPtr;
  logic [AW-1:0] r_rdPtr;
  logic [AW:0]   r_count;
  logic [AW:0]   r_msgCnt;
  logic          r_overflow;

  logic w_wrEn;
  logic w_popEn;
  logic w_wrEom;
  logic w_popEom;

  assign o_empty       = (r_count == '0);
  assign o_full        = (r_count == FULL_COUNT);
  assign o_headData    = r_mem[r_rdPtr];
  assign o_hasMsg      = (r_msgCnt != '0);
  assign o_overflow    = r_overflow;

  // A byte offered to a full buffer is dropped, even if a pop happens that cycle.
  assign w_wrEn        = i_wrValid && !o_full;
  assign w_popEn       = i_pop && !o_empty;
  assign w_wrEom       = w_wrEn && (i_wrData == EOM);
  assign w_popEom      = w_popEn && (o_headData == EOM);

  // The buffer goes empty after this pop only if no byte arrives in the same cycle.
  assign o_drainsOnPop = (r_count == ONE_COUNT) && !w_wrEn;

  // Storage array; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (w_wrEn) begin
      r_mem[r_wrPtr] <= i_wrData;
    end
  end

  // Pointer, occupancy, message count and drop-flag bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wrPtr    <= '0;
      r_rdPtr    <= '0;
      r_count    <= '0;
      r_msgCnt   <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wrEn) begin
        r_wrPtr <= r_wrPtr + 1'b1;
      end
      if (w_popEn) begin
        r_rdPtr <= r_rdPtr + 1'b1;
      end
      case ({w_wrEn, w_popEn})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      case ({w_wrEom, w_popEom})
        2'b10:   r_msgCnt <= r_msgCnt + 1'b1;
        2'b01:   r_msgCnt <= r_msgCnt - 1'b1;
        default: r_msgCnt <= r_msgCnt;
      endcase
      if (i_wrValid && o_full) begin
        r_overflow <= 1'b1;
      end
    end
  end

endmodule

// Top level: two buffers feeding a round-robin, message-granular push arbiter.
module uart_tx_arbiter #(
  parameter int         DEPTH = 16,
  parameter logic [7:0] EOM   = 8'h0A,
  parameter logic [7:0] TAG0  = 8'h53,
  parameter logic [7:0] TAG1  = 8'h44
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] i_req0_data,
  input  logic       i_req0_valid,
  input  logic [7:0] i_req1_data,
  input  logic       i_req1_valid,
  input  logic       i_fifo_full,
  output logic       o_push,
  output logic [7:0] o_push_data,
  output logic [1:0] o_grant,
  output logic [1:0] o_overflow
);

  // Elaboration-time sanity checks on the configuration.
  if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_badDepth
    $error("uart_tx_arbiter: DEPTH must be a power of two and at least 4");
  end
  if (TAG0 == TAG1) begin : g_badTags
    $error("uart_tx_arbiter: TAG0 and TAG1 must differ so streams stay distinguishable");
  end

`ifdef UART_ARB_TAG_EN
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TAG0,
    ST_TAG1,
    ST_GRANT0,
    ST_GRANT1
  } arbState_e;
  localparam arbState_e ST_START0 = ST_TAG0;
  localparam arbState_e ST_START1 = ST_TAG1;
`else
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GRANT0,
    ST_GRANT1
  } arbState_e;
  localparam arbState_e ST_START0 = ST_GRANT0;
  localparam arbState_e ST_START1 = ST_GRANT1;
`endif

  arbState_e  r_state;
  arbState_e  w_nextState;
  logic       r_lastServed;
  logic       w_lastServedNext;
  logic       r_push;
  logic [7:0] r_pushData;
  logic       w_pushNext;
  logic [7:0] w_pushDataNext;

  logic       w_pop0;
  logic       w_pop1;
  logic [7:0] w_head0;
  logic [7:0] w_head1;
  logic       w_empty0;
  logic       w_empty1;
  logic       w_full0;
  logic       w_full1;
  logic       w_hasMsg0;
  logic       w_hasMsg1;
  logic       w_drains0;
  logic       w_drains1;
  logic       w_elig0;
  logic       w_elig1;

  UartArbFifo #(.DEPTH(DEPTH), .EOM(EOM)) u_buf0 (
    .clk           (clk),
    .rst           (rst),
    .i_wrData      (i_req0_data),
    .i_wrValid     (i_req0_valid),
    .i_pop         (w_pop0),
    .o_headData    (w_head0),
    .o_empty       (w_empty0),
    .o_full        (w_full0),
    .o_hasMsg      (w_hasMsg0),
    .o_drainsOnPop (w_drains0),
    .o_overflow    (o_overflow[0])
  );

  UartArbFifo #(.DEPTH(DEPTH), .EOM(EOM)) u_buf1 (
    .clk           (clk),
    .rst           (rst),
    .i_wrData      (i_req1_data),
    .i_wrValid     (i_req1_valid),
    .i_pop         (w_pop1),
    .o_headData    (w_head1),
    .o_empty       (w_empty1),
    .o_full        (w_full1),
    .o_hasMsg      (w_hasMsg1),
    .o_drainsOnPop (w_drains1),
    .o_overflow    (o_overflow[1])
  );

  // A full buffer with no complete message is flushed so it cannot wedge the stream.
  assign w_elig0 = w_hasMsg0 || w_full0;
  assign w_elig1 = w_hasMsg1 || w_full1;

  assign o_push      = r_push;
  assign o_push_data = r_pushData;

  // State, round-robin pointer and the registered push port.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_lastServed <= 1'b1;
      r_push       <= 1'b0;
      r_pushData   <= 8'h00;
    end else begin
      r_state      <= w_nextState;
      r_lastServed <= w_lastServedNext;
      r_push       <= w_pushNext;
      r_pushData   <= w_pushDataNext;
    end
  end

  // Grant selection and per-cycle pop/push decisions for the current owner.
  always_comb begin
    w_nextState      = r_state;
    w_lastServedNext = r_lastServed;
    w_pop0           = 1'b0;
    w_pop1           = 1'b0;
    w_pushNext       = 1'b0;
    w_pushDataNext   = r_pushData;
    case (r_state)
      ST_IDLE: begin
        if (w_elig0 && (!w_elig1 || r_lastServed)) begin
          w_nextState      = ST_START0;
          w_lastServedNext = 1'b0;
        end else if (w_elig1) begin
          w_nextState      = ST_START1;
          w_lastServedNext = 1'b1;
        end
      end
`ifdef UART_ARB_TAG_EN
      ST_TAG0: begin
        if (!i_fifo_full) begin
          w_pushNext     = 1'b1;
          w_pushDataNext = TAG0;
          w_nextState    = ST_GRANT0;
        end
      end
      ST_TAG1: begin
        if (!i_fifo_full) begin
          w_pushNext     = 1'b1;
          w_pushDataNext = TAG1;
          w_nextState    = ST_GRANT1;
        end
      end
`endif
      ST_GRANT0: begin
        if (w_empty0) begin
          w_nextState = ST_IDLE;
        end else if (!i_fifo_full) begin
          w_pop0         = 1'b1;
          w_pushNext     = 1'b1;
          w_pushDataNext = w_head0;
          if (w_head0 == EOM || w_drains0) begin
            w_nextState = ST_IDLE;
          end
        end
      end
      ST_GRANT1: begin
        if (w_empty1) begin
          w_nextState = ST_IDLE;
        end else if (!i_fifo_full) begin
          w_pop1         = 1'b1;
          w_pushNext     = 1'b1;
          w_pushDataNext = w_head1;
          if (w_head1 == EOM || w_drains1) begin
            w_nextState = ST_IDLE;
          end
        end
      end
      default: begin
        w_nextState = ST_IDLE;
      end
    endcase
  end

  // One-hot owner indication, covering the tag phase as well as the data phase.
  always_comb begin
    o_grant = 2'b00;
    case (r_state)
`ifdef UART_ARB_TAG_EN
      ST_TAG0:   o_grant = 2'b01;
      ST_TAG1:   o_grant = 2'b10;
`endif
      ST_GRANT0: o_grant = 2'b01;
      ST_GRANT1: o_grant = 2'b10;
      default:   o_grant = 2'b00;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed messages from both requesters, expected
// output bytes queued at stimulus time and consumed by an independent monitor.
module tb_uart_tx_arbiter;

`ifdef UART_ARB_TAG_EN
  localparam bit TAG_EN = 1'b1;
`else
  localparam bit TAG_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req0Data;
  logic       req0Valid;
  logic [7:0] req1Data;
  logic       req1Valid;
  logic       fifoFull;
  logic       push;
  logic [7:0] pushData;
  logic [1:0] grant;
  logic [1:0] overflow;

  int         total = 0;
  int         bad = 0;
  logic [7:0] expQ [$];

  uart_tx_arbiter dut (
    .clk          (clk),
    .rst          (rst),
    .i_req0_data  (req0Data),
    .i_req0_valid (req0Valid),
    .i_req1_data  (req1Data),
    .i_req1_valid (req1Valid),
    .i_fifo_full  (fifoFull),
    .o_push       (push),
    .o_push_data  (pushData),
    .o_grant      (grant),
    .o_overflow   (overflow)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  always #5 clk = ~clk;

  // Single point where every comparison is counted.
  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Queue the bytes one requester's message should produce, tag first when enabled.
  task automatic expectMsg(input int owner, input string s);
    if (TAG_EN) begin
      expQ.push_back(owner == 1 ? 8'h44 : 8'h53);
    end
    for (int i = 0; i < s.len(); i++) begin
      expQ.push_back(s[i]);
    end
  endtask

  // Strobe both requesters byte by byte; returns at the falling edge after the last byte.
  task automatic applyStimulus(input string s0, input string s1);
    int n;
    n = (s0.len() > s1.len()) ? s0.len() : s1.len();
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      req0Valid = (i < s0.len());
      req0Data  = (i < s0.len()) ? s0[i] : 8'h00;
      req1Valid = (i < s1.len());
      req1Data  = (i < s1.len()) ? s1[i] : 8'h00;
    end
    @(negedge clk);
    req0Valid = 1'b0;
    req1Valid = 1'b0;
  endtask

  // Wait, bounded, until every expected byte has appeared and the port is idle.
  task automatic waitDrain(input int maxCycles, input string name);
    int n;
    n = 0;
    while ((expQ.size() != 0 || grant != 2'b00 || push) && n < maxCycles) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput({name, "Pending"}, 32'(expQ.size()), 32'd0);
    checkOutput({name, "GrantIdle"}, 32'(grant), 32'd0);
  endtask

  task automatic doReset();
    @(negedge clk);
    rst       = 1'b1;
    req0Valid = 1'b0;
    req1Valid = 1'b0;
    fifoFull  = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    expQ.delete();
  endtask

  // Monitor: every push is matched against the head of the expected queue.
  initial begin : scoreboardMonitor
    logic       fullAtEdge;
    logic [7:0] expByte;
    forever begin
      @(posedge clk);
      fullAtEdge = fifoFull;
      #1;
      if (push) begin
        checkOutput("pushAfterFull", 32'(fullAtEdge), 32'd0);
        if (expQ.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL unexpectedPush: got byte 0x%0h, expected no push", pushData);
        end else begin
          expByte = expQ.pop_front();
          checkOutput("pushData", 32'(pushData), 32'(expByte));
        end
      end
    end
  end

  // Absolute bound on simulated time.
  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected test done");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed test sequence.
  initial begin : mainSequence
    rst       = 1'b1;
    req0Valid = 1'b0;
    req0Data  = 8'h00;
    req1Valid = 1'b0;
    req1Data  = 8'h00;
    fifoFull  = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("rstPush", 32'(push), 32'd0);
    checkOutput("rstPushData", 32'(pushData), 32'd0);
    checkOutput("rstGrant", 32'(grant), 32'd0);
    checkOutput("rstOverflow", 32'(overflow), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] single message from req0 with latency check");
    expectMsg(0, "12cm\n");
    applyStimulus("12cm\n", "");
    @(posedge clk);
    #1;
    checkOutput("latGrant", 32'(grant), 32'h1);
    checkOutput("latNoPushYet", 32'(push), 32'd0);
    @(posedge clk);
    #1;
    checkOutput("latFirstPush", 32'(push), 32'd1);
    waitDrain(40, "msg1");

    $display("[TB] downstream full for 4 cycles mid-message");
    expectMsg(0, "PQRSTU\n");
    applyStimulus("PQRSTU\n", "");
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    fifoFull = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      checkOutput("stallNoPush", 32'(push), 32'd0);
      checkOutput("stallGrantHeld", 32'(grant), 32'h1);
    end
    @(negedge clk);
    fifoFull = 1'b0;
    waitDrain(40, "stall");

    $display("[TB] simultaneous messages and round robin");
    doReset();
    expectMsg(0, "AB\n");
    expectMsg(1, "xy\n");
    applyStimulus("AB\n", "xy\n");
    @(posedge clk);
    #1;
    checkOutput("tie1Grant", 32'(grant), 32'h1);
    waitDrain(40, "tie1");
    expectMsg(0, "k\n");
    applyStimulus("k\n", "");
    waitDrain(40, "solo");
    expectMsg(1, "34\n");
    expectMsg(0, "12\n");
    applyStimulus("12\n", "34\n");
    @(posedge clk);
    #1;
    checkOutput("tie2Grant", 32'(grant), 32'h2);
    waitDrain(40, "tie2");

    $display("[TB] req1 overfills its buffer without an end-of-message byte");
    doReset();
    expectMsg(1, "abcdefghijklmnop");
    applyStimulus("", "abcdefghijklmnopq");
    checkOutput("overflowFlag", 32'(overflow), 32'h2);
    waitDrain(60, "flush");
    checkOutput("overflowSticky", 32'(overflow), 32'h2);

    $display("[TB] reset during the second byte of a message");
    doReset();
    expectMsg(0, "abcd\n");
    applyStimulus("abcd\n", "");
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("preResetPending", 32'(expQ.size()), 32'(TAG_EN ? 4 : 3));
    rst = 1'b1;
    expQ.delete();
    @(posedge clk);
    #1;
    checkOutput("midRstPush", 32'(push), 32'd0);
    checkOutput("midRstGrant", 32'(grant), 32'd0);
    checkOutput("midRstOverflow", 32'(overflow), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(posedge clk);
    expectMsg(0, "z\n");
    applyStimulus("z\n", "");
    waitDrain(40, "postRst");

    repeat (5) @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
